// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package muldiv_pkg;

  // Instruction funct codes recognised by the multiply unit
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle between the execute stage and the multiply controller.
// Latency: n/a (wires only).
// Backpressure: requester holds start until ready=1; results are not backpressured.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Execute-stage side: issues requests, observes status and HI/LO
  modport master (
    output start, funct, dataA, dataB,
    input  ready, busy, done, hi, lo
  );

  // Controller side
  modport slave (
    input  start, funct, dataA, dataB,
    output ready, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl_shift_add_step.sv
// One shift-add multiply step: conditional add of the multiplicand into the upper half, then shift right.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module shift_add_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [WIDTH:0] sum;

  // W+1-bit add so the carry out becomes the new top bit after the shift
  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (prod[0]) begin
      sum = sum + {1'b0, mcand};
    end
    prod_next = {sum, prod[WIDTH-1:1]};
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative WIDTHxWIDTH multiply; commits the product to HI/LO (signed MULT when MULDIV_SIGNED_EN is defined).
// Latency: accept at edge T, HI/LO written and done pulsed by edge T+34 (one op per 35 cycles).
// Backpressure: ready=0 while busy; start is ignored then and the requester must hold it.
module muldiv_ctrl #(
  parameter int         WIDTH       = 32,
  parameter logic [5:0] FUNCT_MULTU = muldiv_pkg::FUNCT_MULTU,
  parameter logic [5:0] FUNCT_MULT  = muldiv_pkg::FUNCT_MULT
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_ctrl_if.slave  bus
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH);

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_step;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               is_signed_op;
  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   a_load;
  logic [WIDTH-1:0]   b_load;

  logic               busy_c;
  logic               step_en;
  logic               fix_en;
  logic               commit;

`ifdef MULDIV_SIGNED_EN
  logic               neg;
  logic               neg_load;
`endif

  assign is_signed_op = SIGNED_EN && (bus.funct == FUNCT_MULT);
  assign accept       = (state == IDLE) && bus.start &&
                        ((bus.funct == FUNCT_MULTU) || is_signed_op);
  assign last_step    = (count == CW'(WIDTH - 1));

  // Operand conditioning at acceptance: magnitudes and result sign for signed ops
`ifdef MULDIV_SIGNED_EN
  always_comb begin
    a_load   = bus.dataA;
    b_load   = bus.dataB;
    neg_load = 1'b0;
    if (is_signed_op) begin
      a_load   = bus.dataA[WIDTH-1] ? -bus.dataA : bus.dataA;
      b_load   = bus.dataB[WIDTH-1] ? -bus.dataB : bus.dataB;
      neg_load = bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1];
    end
  end
`else
  always_comb begin
    a_load = bus.dataA;
    b_load = bus.dataB;
  end
`endif

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .prod      (prod),
    .mcand     (mcand),
    .prod_next (prod_step)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: one accepted op walks RUN x WIDTH, FIX, DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: status and datapath enables decoded from the current state
  always_comb begin
    busy_c  = 1'b1;
    step_en = 1'b0;
    fix_en  = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE:    busy_c  = 1'b0;
      RUN:     step_en = 1'b1;
      FIX:     fix_en  = 1'b1;
      DONE:    commit  = 1'b1;
      default: busy_c  = 1'b0;
    endcase
  end

  // Operand, product and step-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      prod  <= '0;
      count <= '0;
`ifdef MULDIV_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else if (accept) begin
      mcand <= a_load;
      prod  <= {{WIDTH{1'b0}}, b_load};
      count <= '0;
`ifdef MULDIV_SIGNED_EN
      neg   <= neg_load;
`endif
    end else if (step_en) begin
      prod  <= prod_step;
      count <= count + 1'b1;
    end else if (fix_en) begin
`ifdef MULDIV_SIGNED_EN
      if (neg) begin
        prod <= -prod;
      end
`endif
    end
  end

  // Architectural HI/LO only move on the commit edge; done flags that edge for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        hi_q <= prod[2*WIDTH-1:WIDTH];
        lo_q <= prod[WIDTH-1:0];
      end
    end
  end

  assign bus.busy  = busy_c;
  assign bus.ready = !busy_c;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
